// File: rtl/uart_link_monitor.sv
// rtl/uart_link_monitor.sv - round-robin echo test of N UART links with per-link verdicts
//
// Polls each channel in turn: sends the sampled cmd byte through that channel's
// transmitter and waits for the same byte to come back on its receiver. A channel
// gets a bounded number of attempts, then a pass or fail verdict is recorded.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   enable                level; high runs the polling loop
//   cmd                   byte to send, sampled when an attempt starts
//   tx_data/tx_start      per-channel byte and one-cycle start pulse to the transmitters
//   tx_busy               per-channel transmitter busy
//   rx_data/rx_done       per-channel received byte and receive-complete strobe
//   rx_parity_error       per-channel parity error, valid with rx_done
//   link_ok/checked       last verdict per channel / channel has a verdict
//   err_cnt               per-channel saturating failed-verdict counter (8 bits each)
//   fault                 registered OR of checked & ~link_ok
//   cur_ch                channel currently being polled
module uart_link_monitor #(
    parameter int  N_CH        = 4,
    parameter int  DATA_W      = 8,
    parameter int  STARTUP_CYC = 24000000,
    parameter int  TIMEOUT_CYC = 240,
    parameter int  GAP_CYC     = 48,
    parameter int  MAX_RETRY   = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [DATA_W-1:0]      cmd,
    output logic [N_CH*DATA_W-1:0] tx_data,
    output logic [N_CH-1:0]        tx_start,
    input  logic [N_CH-1:0]        tx_busy,
    input  logic [N_CH*DATA_W-1:0] rx_data,
    input  logic [N_CH-1:0]        rx_done,
    input  logic [N_CH-1:0]        rx_parity_error,
    output logic [N_CH-1:0]        link_ok,
    output logic [N_CH-1:0]        checked,
    output logic [N_CH*8-1:0]      err_cnt,
    output logic                   fault,
    output logic [CH_W-1:0]        cur_ch
);

    localparam int AT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTUP,
        S_SEND,
        S_WAIT_ECHO,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [AT_W-1:0]         attempt_q, attempt_d;
    logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
    logic [DATA_W-1:0]       sent_q, sent_d;
    logic [N_CH*DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [N_CH-1:0]         tx_start_q, tx_start_d;
    logic [N_CH-1:0]         link_ok_q, link_ok_d;
    logic [N_CH-1:0]         checked_q, checked_d;
    logic [N_CH*8-1:0]       err_cnt_q, err_cnt_d;
    logic                    fault_q, fault_d;

    logic                    enter_send;
    logic                    fail_attempt;
    logic                    pass_echo;
    logic                    expired;
    logic [DATA_W-1:0]       echo_byte;
    logic [7:0]              err_cur;

    // One counter serves as startup delay, attempt timer and inter-channel gap,
    // since those phases never overlap.
    assign expired   = (cnt_q >= 32'(TIMEOUT_CYC - 1));
    assign echo_byte = rx_data[int'(cur_ch_q)*DATA_W +: DATA_W];
    assign err_cur   = err_cnt_q[int'(cur_ch_q)*8 +: 8];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        attempt_d    = attempt_q;
        cur_ch_d     = cur_ch_q;
        sent_d       = sent_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = '0;
        link_ok_d    = link_ok_q;
        checked_d    = checked_q;
        err_cnt_d    = err_cnt_q;
        fault_d      = |(checked_q & ~link_ok_q);
        enter_send   = 1'b0;
        fail_attempt = 1'b0;
        pass_echo    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_STARTUP;
                    cnt_d   = '0;
                end
            end
            S_STARTUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= 32'(STARTUP_CYC - 1)) begin
                    cur_ch_d   = '0;
                    attempt_d  = '0;
                    enter_send = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SEND: begin
                // Echo strobes are ignored here; the byte has not been sent yet.
                if (expired) begin
                    fail_attempt = 1'b1;
                end else if (!tx_busy[cur_ch_q]) begin
                    tx_start_d[cur_ch_q] = 1'b1;
                    state_d              = S_WAIT_ECHO;
                    cnt_d                = cnt_q + 32'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_ECHO: begin
                // An echo arriving on the expiry cycle still counts as an echo.
                if (rx_done[cur_ch_q]) begin
                    if (echo_byte == sent_q && !rx_parity_error[cur_ch_q]) begin
                        pass_echo = 1'b1;
                    end else begin
                        fail_attempt = 1'b1;
                    end
                end else if (expired) begin
                    fail_attempt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (cnt_q >= 32'(GAP_CYC - 1)) begin
                    cur_ch_d  = (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
                    attempt_d = '0;
                    cnt_d     = '0;
                    if (enable) begin
                        enter_send = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (fail_attempt) begin
            if (attempt_q < AT_W'(MAX_RETRY)) begin
                attempt_d  = attempt_q + 1'b1;
                enter_send = 1'b1;
            end else begin
                link_ok_d[cur_ch_q] = 1'b0;
                checked_d[cur_ch_q] = 1'b1;
                if (err_cur != 8'hFF) begin
                    err_cnt_d[int'(cur_ch_q)*8 +: 8] = err_cur + 8'd1;
                end
                state_d = S_GAP;
                cnt_d   = '0;
            end
        end

        if (pass_echo) begin
            link_ok_d[cur_ch_q] = 1'b1;
            checked_d[cur_ch_q] = 1'b1;
            state_d             = S_GAP;
            cnt_d               = '0;
        end

        // Every attempt re-samples cmd and restarts the attempt timer.
        if (enter_send) begin
            state_d                                   = S_SEND;
            cnt_d                                     = '0;
            sent_d                                    = cmd;
            tx_data_d[int'(cur_ch_d)*DATA_W +: DATA_W] = cmd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            attempt_q  <= '0;
            cur_ch_q   <= '0;
            sent_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= '0;
            link_ok_q  <= '0;
            checked_q  <= '0;
            err_cnt_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            attempt_q  <= attempt_d;
            cur_ch_q   <= cur_ch_d;
            sent_q     <= sent_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            link_ok_q  <= link_ok_d;
            checked_q  <= checked_d;
            err_cnt_q  <= err_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign link_ok  = link_ok_q;
    assign checked  = checked_q;
    assign err_cnt  = err_cnt_q;
    assign fault    = fault_q;
    assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_uart_link_monitor.sv
// tb/tb_uart_link_monitor.sv - self-checking bench for uart_link_monitor
module tb_uart_link_monitor;

    localparam int S_CYC = 10;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  cmd;
    logic [15:0] tx_data;
    logic [1:0]  tx_start;
    logic [1:0]  tx_busy;
    logic [15:0] rx_data;
    logic [1:0]  rx_done;
    logic [1:0]  rx_parity_error;
    logic [1:0]  link_ok;
    logic [1:0]  checked;
    logic [15:0] err_cnt;
    logic        fault;
    logic [0:0]  cur_ch;

    uart_link_monitor #(
        .N_CH(2), .DATA_W(8), .STARTUP_CYC(S_CYC), .TIMEOUT_CYC(20),
        .GAP_CYC(4), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cmd(cmd),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_done(rx_done), .rx_parity_error(rx_parity_error),
        .link_ok(link_ok), .checked(checked), .err_cnt(err_cnt),
        .fault(fault), .cur_ch(cur_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Echo behaviour per channel:
    // 0 loopback, 1 echoes 8'h55, 2 silent (plus a stray strobe on ch1),
    // 3 correct byte with parity error, 4 silent twice then echo on the timeout cycle,
    // 5 transmitter stuck busy with correct-looking strobes
    typedef struct {
        int         mode0;
        int         mode1;
        logic [7:0] cmd;
        logic [1:0] exp_ok;
        logic [1:0] exp_chk;
        logic [7:0] exp_e0;
        logic [7:0] exp_e1;
        logic       exp_fault;
        int         n0;
        int         n1;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } sb_t;

    int  total = 0;
    int  bad   = 0;
    int  mode[2];
    sb_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ch, input logic [7:0] data, input int n);
        sb_t e;
        e.ch   = ch;
        e.data = data;
        repeat (n) sbq.push_back(e);
    endtask

    task automatic apply_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        sbq.delete();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_cur(input logic [0:0] val, input int budget);
        for (int i = 0; i < budget && cur_ch != val; i++) @(negedge clk);
        if (cur_ch != val) chk("wait_cur_timeout", cur_ch, val);
    endtask

    // Echo responder
    initial begin : responder
        int         pend[2];
        logic [7:0] rbyte[2];
        logic       rperr[2];
        int         nstart[2];
        int         stray;
        int         tick;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 0; rbyte[c] = 8'h00; rperr[c] = 1'b0; nstart[c] = 0;
        end
        stray = 0;
        tick  = 0;
        rx_done = '0;
        rx_data = '0;
        rx_parity_error = '0;
        forever begin
            @(negedge clk);
            rx_done = '0;
            rx_parity_error = '0;
            if (!reset_n) begin
                for (int c = 0; c < 2; c++) begin
                    pend[c] = 0; nstart[c] = 0;
                end
                stray = 0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (pend[c] > 0) begin
                        pend[c]--;
                        if (pend[c] == 0) begin
                            rx_done[c]         = 1'b1;
                            rx_data[c*8 +: 8]  = rbyte[c];
                            rx_parity_error[c] = rperr[c];
                        end
                    end
                    if (mode[c] == 5 && (tick % 7) == 0) begin
                        rx_done[c]        = 1'b1;
                        rx_data[c*8 +: 8] = cmd;
                    end
                    if (tx_start[c]) begin
                        rbyte[c] = tx_data[c*8 +: 8];
                        rperr[c] = 1'b0;
                        case (mode[c])
                            0: pend[c] = 3;
                            1: begin pend[c] = 3; rbyte[c] = 8'h55; end
                            2: if (c == 0) stray = 5;
                            3: begin pend[c] = 3; rperr[c] = 1'b1; end
                            4: if (nstart[c] >= 2) pend[c] = 18;
                            default: ;
                        endcase
                        nstart[c]++;
                    end
                end
                if (stray > 0) begin
                    stray--;
                    if (stray == 0) begin
                        rx_done[1]    = 1'b1;
                        rx_data[15:8] = cmd;
                    end
                end
                tick++;
            end
        end
    end

    // Scoreboard: every tx_start pulse pops one expected {channel, byte}
    initial begin : monitor
        logic [1:0] prev;
        sb_t        e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (reset_n && tx_start != 2'b00) begin
                chk("start_onehot", $countones(tx_start), 1);
                chk("start_single_cycle", {30'd0, prev}, 0);
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_start", {30'd0, tx_start}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_start_ch", {30'd0, tx_start}, 32'(2'b01 << e.ch));
                    chk("sb_start_data", {24'd0, tx_data[e.ch*8 +: 8]}, {24'd0, e.data});
                end
            end
            prev = reset_n ? tx_start : 2'b00;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        apply_reset();
        mode[0] = v.mode0;
        mode[1] = v.mode1;
        cmd     = v.cmd;
        tx_busy = {v.mode1 == 5, v.mode0 == 5};
        push_exp(0, v.cmd, v.n0);
        push_exp(1, v.cmd, v.n1);
        enable = 1'b1;
        for (int i = 0; i < 2000 && !checked[1]; i++) @(negedge clk);
        chk($sformatf("v%0d_round_done", idx), {31'd0, checked[1]}, 1);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        chk($sformatf("v%0d_link_ok", idx), {30'd0, link_ok}, {30'd0, v.exp_ok});
        chk($sformatf("v%0d_checked", idx), {30'd0, checked}, {30'd0, v.exp_chk});
        chk($sformatf("v%0d_err0", idx), {24'd0, err_cnt[7:0]}, {24'd0, v.exp_e0});
        chk($sformatf("v%0d_err1", idx), {24'd0, err_cnt[15:8]}, {24'd0, v.exp_e1});
        chk($sformatf("v%0d_fault", idx), {31'd0, fault}, {31'd0, v.exp_fault});
        chk($sformatf("v%0d_sb_left", idx), sbq.size(), 0);
        sbq.delete();
        tx_busy = 2'b00;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[9];
        int   lat;
        vecs[0] = '{0, 0, 8'hEE, 2'b11, 2'b11, 8'd0, 8'd0, 1'b0, 1, 1};
        vecs[1] = '{0, 1, 8'hEE, 2'b01, 2'b11, 8'd0, 8'd1, 1'b1, 1, 3};
        vecs[2] = '{2, 0, 8'h3C, 2'b10, 2'b11, 8'd1, 8'd0, 1'b1, 3, 1};
        vecs[3] = '{4, 0, 8'hA5, 2'b11, 2'b11, 8'd0, 8'd0, 1'b0, 3, 1};
        vecs[4] = '{3, 0, 8'h0F, 2'b10, 2'b11, 8'd1, 8'd0, 1'b1, 3, 1};
        vecs[5] = '{5, 0, 8'h81, 2'b10, 2'b11, 8'd1, 8'd0, 1'b1, 0, 1};
        vecs[6] = '{0, 4, 8'h7E, 2'b11, 2'b11, 8'd0, 8'd0, 1'b0, 1, 3};
        vecs[7] = '{1, 1, 8'h55, 2'b11, 2'b11, 8'd0, 8'd0, 1'b0, 1, 1};
        vecs[8] = '{1, 3, 8'hC3, 2'b00, 2'b11, 8'd1, 8'd1, 1'b1, 3, 3};

        mode[0] = 0;
        mode[1] = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        cmd     = 8'h00;
        tx_busy = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {30'd0, tx_start}, 0);
        chk("rst_tx_data", {16'd0, tx_data}, 0);
        chk("rst_link_ok", {30'd0, link_ok}, 0);
        chk("rst_checked", {30'd0, checked}, 0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 0);
        chk("rst_fault", {31'd0, fault}, 0);
        chk("rst_cur_ch", {31'd0, cur_ch}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Fault rises exactly one cycle after the failing verdict
        apply_reset();
        mode[0] = 0;
        mode[1] = 1;
        cmd     = 8'hEE;
        push_exp(0, 8'hEE, 1);
        push_exp(1, 8'hEE, 3);
        enable = 1'b1;
        for (int i = 0; i < 2000 && err_cnt[15:8] != 8'd1; i++) @(negedge clk);
        chk("ft_err1_seen", {24'd0, err_cnt[15:8]}, 1);
        chk("ft_fault_same_cycle", {31'd0, fault}, 0);
        @(negedge clk);
        chk("ft_fault_next_cycle", {31'd0, fault}, 1);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("ft_sb_left", sbq.size(), 0);

        // 300 failing rounds on ch0: counter saturates
        apply_reset();
        mode[0] = 2;
        mode[1] = 0;
        cmd     = 8'h5A;
        for (int r = 0; r < 300; r++) begin
            push_exp(0, 8'h5A, 3);
            push_exp(1, 8'h5A, 1);
        end
        enable = 1'b1;
        for (int r = 0; r < 300; r++) begin
            wait_cur(1'b1, 400);
            if (r == 299) enable = 1'b0;
            wait_cur(1'b0, 400);
        end
        repeat (10) @(negedge clk);
        chk("sat_err0", {24'd0, err_cnt[7:0]}, 255);
        chk("sat_err1", {24'd0, err_cnt[15:8]}, 0);
        chk("sat_link_ok", {30'd0, link_ok}, 2'b10);
        chk("sat_fault", {31'd0, fault}, 1);
        chk("sat_sb_left", sbq.size(), 0);

        // Asynchronous reset in the middle of WAIT_ECHO
        push_exp(0, 8'h5A, 3);
        enable = 1'b1;
        for (int i = 0; i < 200 && !tx_start[0]; i++) @(negedge clk);
        chk("ar_start_seen", {31'd0, tx_start[0]}, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_tx_start", {30'd0, tx_start}, 0);
        chk("ar_tx_data", {16'd0, tx_data}, 0);
        chk("ar_link_ok", {30'd0, link_ok}, 0);
        chk("ar_checked", {30'd0, checked}, 0);
        chk("ar_err_cnt", {16'd0, err_cnt}, 0);
        chk("ar_fault", {31'd0, fault}, 0);
        chk("ar_cur_ch", {31'd0, cur_ch}, 0);
        @(negedge clk);
        sbq.delete();
        enable  = 1'b0;
        mode[0] = 0;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("ar_idle_checked", {30'd0, checked}, 0);
        chk("ar_idle_err_cnt", {16'd0, err_cnt}, 0);

        // Startup latency from enable rise to first start pulse
        push_exp(0, 8'h5A, 1);
        enable = 1'b1;
        lat = 0;
        while (lat < 100 && tx_start == 2'b00) begin
            @(negedge clk);
            lat++;
        end
        enable = 1'b0;
        chk("su_lat_min", {31'd0, lat >= S_CYC + 1}, 1);
        chk("su_lat_max", {31'd0, lat <= S_CYC + 2}, 1);
        repeat (60) @(negedge clk);
        chk("su_link_ok", {30'd0, link_ok}, 2'b01);
        chk("su_checked", {30'd0, checked}, 2'b01);
        chk("su_sb_left", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
